mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 4, maximum consecutive granted cycles per grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  4  per-requester request; bit i held high while requester i wants the mux.
REQ-005 d  input  4  per-requester data bit; d[i] is the mux data input for requester i.
REQ-006 grant  output  4  one-hot grant, registered; all-zero when no grant is active.
REQ-007 sel  output  2  registered mux select, equal to the index of the granted requester.
REQ-008 y  output  1  registered muxed data.
REQ-009 y_valid  output  1  registered; high when y carries a sample taken in the previous cycle.
REQ-010 busy  output  1  registered; high in state BUSY.

Function
REQ-011 FSM states: IDLE, BUSY; encoding free; no other reachable states.
REQ-012 Internal round-robin pointer ptr[1:0] gives the highest-priority index; priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-013 IDLE with req==0: stay IDLE, grant=0, busy=0; sel and ptr hold.
REQ-014 IDLE with req!=0: winner = first set req bit in priority order; next edge: state=BUSY, sel=winner, grant=1<<winner, hold counter cnt=0.
REQ-015 Grant latency: req rising in IDLE -> grant visible after exactly one clock edge.
REQ-016 BUSY, transfer cycle (req[sel]=1): next edge y=d[sel], y_valid=1, cnt=cnt+1.
REQ-017 BUSY with req[sel]=0: release; next edge state=IDLE, grant=0, y_valid=0, ptr=sel+1 mod 4.
REQ-018 BUSY transfer cycle with cnt==HOLD_MAX-1: sample taken per REQ-016 AND release per REQ-017 on the same edge; counts exactly HOLD_MAX samples per grant.
REQ-019 Release always passes through one IDLE cycle before the next grant; no direct BUSY-to-BUSY handoff.
REQ-020 Wrap-around: ptr after releasing index 3 is 0.
REQ-021 Requests from non-granted requesters are ignored during BUSY; changes in them do not affect sel, cnt or y.
REQ-022 Changes of d[sel] in a transfer cycle appear on y at the next edge; d of non-granted requesters never reaches y.
REQ-023 Outside transfer cycles y holds its last value and y_valid=0.
REQ-024 grant, sel and busy never change except on a clock edge; grant always has at most one bit set.
REQ-025 cnt is 4 bits wide and never exceeds HOLD_MAX-1.

Reset
REQ-026 rst_n=0 at a rising edge forces: state=IDLE, ptr=0, sel=0, grant=0, y=0, y_valid=0, busy=0, cnt=0.
REQ-027 Reset has priority over all other inputs, including mid-grant; reset in BUSY aborts the grant with no further samples.
REQ-028 The first edge with rst_n=1 is a normal IDLE edge (arbitration may occur on it).

Verification
REQ-029 Reset, then req=4'b0001, d=4'b0101 held -> grant=0001 after 1 edge; y_valid=1, y=1 on the next 4 edges (HOLD_MAX=4); then grant=0 for one cycle and ptr=1; re-grant of requester 0 one edge later.
REQ-030 req=4'b1111 held, d=4'b0101 -> grants cycle 0001, 0010, 0100, 1000, 0001, each for 4 samples with one idle cycle between; y sequence per grant: 1,0,1,0.
REQ-031 req=4'b0100 for 2 cycles after grant, then req=0 -> exactly 2 samples with y=1, grant drops on the next edge, ptr=3.
REQ-032 ptr=3, req=4'b1001 -> requester 3 granted first, then requester 0 (wrap-around).
REQ-033 rst_n=0 for one edge during BUSY mid-hold -> all outputs zero after that edge; with req=4'b0010 still high, grant=0010 one edge after rst_n returns high.
REQ-034 HOLD_MAX=1 build, req=4'b0011 -> grants alternate 0001, 0010, each with exactly 1 sample.

Source files
------------

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter granting one of four requesters a muxed data path for up to HOLD_MAX samples
module mux_arbiter #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] d,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       y,
   output logic       y_valid,
   output logic       busy
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state;
   logic [1:0] ptr;
   logic [3:0] cnt;
   logic [7:0] dbl;
   logic [3:0] rot;
   logic [1:0] winner;
   logic       rel;
   // rotate so rot[0] is the requester currently holding top priority
   always_comb begin
      dbl    = {req, req};
      rot    = dbl[ptr +: 4];
      winner = ptr + (rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3);
      rel    = !req[sel] || cnt == 4'(HOLD_MAX - 1);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         sel     <= 2'd0;
         grant   <= 4'd0;
         y       <= 1'b0;
         y_valid <= 1'b0;
         busy    <= 1'b0;
         cnt     <= 4'd0;
      end else if (state == IDLE) begin
         y_valid <= 1'b0;
         if (|req) begin
            state <= BUSY;
            sel   <= winner;
            grant <= 4'b0001 << winner;
            busy  <= 1'b1;
            cnt   <= 4'd0;
         end
      end else begin
         y_valid <= req[sel];
         if (req[sel]) y <= d[sel];
         if (rel) begin
            state <= IDLE;
            grant <= 4'd0;
            busy  <= 1'b0;
            ptr   <= sel + 2'd1;
            cnt   <= 4'd0;
         end else cnt <= cnt + 4'd1;
      end
   end
endmodule
